// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU: opcode and FSM encodings,
// counter width derivation and opcode classification.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4,
        OP_AND = 3'd5,
        OP_OR  = 3'd6,
        OP_XOR = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic logic is_divide(input alu_op_t op);
        logic r;
        case (op)
            OP_DIV, OP_MOD: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative datapath: right-shifting shift-add multiplier and restoring
// divider over one 2*WIDTH accumulator. Exposes the post-step accumulator value.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] opnd_r;
    logic             mode_r;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;

    // One multiply or divide step computed from the current accumulator.
    always_comb begin
        sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        shl_s    = {hi_r, lo_r[WIDTH-1]};
        diff_s   = shl_s - {1'b0, opnd_r};
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        if (mode_r) begin
            // Partial remainder stays below the divisor, so bit WIDTH of the
            // difference is a clean "did not fit" indicator.
            if (!diff_s[WIDTH]) begin
                hi_nxt_s = diff_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_s = shl_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt_s = sum_s[WIDTH:1];
            lo_nxt_s = {sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    assign acc_nxt = {hi_nxt_s, lo_nxt_s};

    // Accumulator and operand registers: load on accept, advance on step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            opnd_r <= {WIDTH{1'b0}};
            mode_r <= 1'b0;
        end else if (load) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= a;
            opnd_r <= b;
            mode_r <= mode;
        end else if (step) begin
            hi_r   <= hi_nxt_s;
            lo_r   <= lo_nxt_s;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential four-flag ALU: single-cycle add/sub/logic, WIDTH-cycle iterative
// multiply/divide/modulo, registered result and N/Z/C/V flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             negativo,
    output logic             cero,
    output logic             acarreo,
    output logic             desbordamiento
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    alu_op_t            op_r;
    logic               busy_r;
    logic               done_r;
    logic               busy_nxt_s;
    logic               done_nxt_s;

    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_hi_r;
    logic               negativo_r;
    logic               cero_r;
    logic               acarreo_r;
    logic               desb_r;

    logic               accept_s;
    logic               go_iter_s;
    logic               last_s;
    logic               upd_s;
    logic [WIDTH-1:0]   res_nxt_s;
    logic [WIDTH-1:0]   hi_nxt_s;
    logic               c_nxt_s;
    logic               v_nxt_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic               cin_s;
    logic [WIDTH:0]     add_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0]   acc_hi_s;
    logic [WIDTH-1:0]   acc_lo_s;

    assign accept_s  = start && (state_r != ITER);
    assign go_iter_s = accept_s && ((op == OP_MUL) || (is_divide(op) && (b != {WIDTH{1'b0}})));
    assign last_s    = (state_r == ITER) && (cnt_r == CNT_LAST);
    assign acc_hi_s  = acc_nxt_s[2*WIDTH-1:WIDTH];
    assign acc_lo_s  = acc_nxt_s[WIDTH-1:0];

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (go_iter_s),
        .step    (state_r == ITER),
        .mode    (op != OP_MUL),
        .a       (a),
        .b       (b),
        .acc_nxt (acc_nxt_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nxt_s = go_iter_s ? ITER : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ITER: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ITER;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ITER:    busy_nxt_s = 1'b1;
            DONE:    done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Status flops, iteration counter and latched opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            op_r   <= OP_ADD;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (accept_s) begin
                cnt_r <= {CNT_W{1'b0}};
                op_r  <= op;
            end else if (state_r == ITER) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Shared adder: SUB is a + ~b + 1, carry-in only honoured for ADD.
    always_comb begin
        if (op == OP_SUB) begin
            b_eff_s = ~b;
            cin_s   = 1'b1;
        end else if (op == OP_ADD) begin
            b_eff_s = b;
            cin_s   = ci;
        end else begin
            b_eff_s = b;
            cin_s   = 1'b0;
        end
        add_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    end

    // Result selection for single-cycle ops on accept, iterative ops on the last step.
    always_comb begin
        upd_s     = 1'b0;
        res_nxt_s = result_r;
        hi_nxt_s  = result_hi_r;
        c_nxt_s   = acarreo_r;
        v_nxt_s   = desb_r;
        if (accept_s && !go_iter_s) begin
            upd_s    = 1'b1;
            hi_nxt_s = {WIDTH{1'b0}};
            c_nxt_s  = 1'b0;
            v_nxt_s  = 1'b0;
            case (op)
                OP_ADD: begin
                    res_nxt_s = add_s[WIDTH-1:0];
                    c_nxt_s   = add_s[WIDTH];
                    v_nxt_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    res_nxt_s = add_s[WIDTH-1:0];
                    c_nxt_s   = add_s[WIDTH];
                    v_nxt_s   = (a[WIDTH-1] != b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
                end
                OP_DIV, OP_MOD: begin
                    // Only reached with b == 0: divide-by-zero short cut.
                    res_nxt_s = {WIDTH{1'b1}};
                    hi_nxt_s  = a;
                    v_nxt_s   = 1'b1;
                end
                OP_AND:  res_nxt_s = a & b;
                OP_OR:   res_nxt_s = a | b;
                OP_XOR:  res_nxt_s = a ^ b;
                default: res_nxt_s = {WIDTH{1'b0}};
            endcase
        end else if (last_s) begin
            upd_s   = 1'b1;
            c_nxt_s = 1'b0;
            v_nxt_s = 1'b0;
            case (op_r)
                OP_MUL: begin
                    res_nxt_s = acc_lo_s;
                    hi_nxt_s  = acc_hi_s;
                    v_nxt_s   = (acc_hi_s != {WIDTH{1'b0}});
                end
                OP_DIV: begin
                    res_nxt_s = acc_lo_s;
                    hi_nxt_s  = acc_hi_s;
                end
                OP_MOD: begin
                    res_nxt_s = acc_hi_s;
                    hi_nxt_s  = acc_lo_s;
                end
                default: begin
                    res_nxt_s = {WIDTH{1'b0}};
                    hi_nxt_s  = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            upd_s = 1'b0;
        end
    end

    // Result and flag registers hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            negativo_r  <= 1'b0;
            cero_r      <= 1'b0;
            acarreo_r   <= 1'b0;
            desb_r      <= 1'b0;
        end else if (upd_s) begin
            result_r    <= res_nxt_s;
            result_hi_r <= hi_nxt_s;
            negativo_r  <= res_nxt_s[WIDTH-1];
            cero_r      <= (res_nxt_s == {WIDTH{1'b0}});
            acarreo_r   <= c_nxt_s;
            desb_r      <= v_nxt_s;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign result         = result_r;
    assign result_hi      = result_hi_r;
    assign negativo       = negativo_r;
    assign cero           = cero_r;
    assign acarreo        = acarreo_r;
    assign desbordamiento = desb_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq at WIDTH = 8, checked against an
// arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    alu_op_t      op = OP_ADD;
    logic [W-1:0] a = 8'h00;
    logic [W-1:0] b = 8'h00;
    logic         ci = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         negativo;
    logic         cero;
    logic         acarreo;
    logic         desbordamiento;

    int total  = 0;
    int passed = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .op             (op),
        .a              (a),
        .b              (b),
        .ci             (ci),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .result_hi      (result_hi),
        .negativo       (negativo),
        .cero           (cero),
        .acarreo        (acarreo),
        .desbordamiento (desbordamiento)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int to_signed8(input int u);
        return (u >= 128) ? u - 256 : u;
    endfunction

    // Reference behaviour from plain integer arithmetic.
    function automatic void model(input alu_op_t o, input int ua, input int ub, input int uci,
                                  output logic [7:0] r, output logic [7:0] hi, output logic [3:0] f);
        int   s;
        int   sv;
        logic c;
        logic v;
        c  = 1'b0;
        v  = 1'b0;
        hi = 8'h00;
        r  = 8'h00;
        case (o)
            OP_ADD: begin
                s  = ua + ub + uci;
                r  = 8'(s);
                c  = (s > 255);
                sv = to_signed8(ua) + to_signed8(ub) + uci;
                v  = (sv > 127) || (sv < -128);
            end
            OP_SUB: begin
                s  = ua - ub;
                r  = 8'(s);
                c  = (ua >= ub);
                sv = to_signed8(ua) - to_signed8(ub);
                v  = (sv > 127) || (sv < -128);
            end
            OP_MUL: begin
                s  = ua * ub;
                r  = 8'(s);
                hi = 8'(s / 256);
                v  = (hi != 8'h00);
            end
            OP_DIV, OP_MOD: begin
                if (ub == 0) begin
                    r  = 8'hFF;
                    hi = 8'(ua);
                    v  = 1'b1;
                end else if (o == OP_DIV) begin
                    r  = 8'(ua / ub);
                    hi = 8'(ua % ub);
                end else begin
                    r  = 8'(ua % ub);
                    hi = 8'(ua / ub);
                end
            end
            OP_AND:  r = 8'(ua & ub);
            OP_OR:   r = 8'(ua | ub);
            OP_XOR:  r = 8'(ua ^ ub);
            default: r = 8'h00;
        endcase
        f = {r[7], (r == 8'h00), c, v};
    endfunction

    function automatic int exp_lat(input alu_op_t o, input int ub);
        if (o == OP_MUL || ((o == OP_DIV || o == OP_MOD) && ub != 0)) return W + 1;
        return 1;
    endfunction

    task automatic check_out(input string tag, input alu_op_t o, input int ua, input int ub, input int uci);
        logic [7:0] r;
        logic [7:0] hi;
        logic [3:0] f;
        model(o, ua, ub, uci, r, hi, f);
        chk({tag, "/result"}, 32'(result), 32'(r));
        chk({tag, "/result_hi"}, 32'(result_hi), 32'(hi));
        chk({tag, "/nzcv"}, 32'({negativo, cero, acarreo, desbordamiento}), 32'(f));
    endtask

    // Called on a falling edge; cycle c0 is the cycle currently being observed.
    task automatic wait_done(input int c0, output int lat);
        int c;
        c = c0;
        while (done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        lat = (done === 1'b1) ? c : -1;
    endtask

    task automatic drive(input alu_op_t o, input int ua, input int ub, input int uci);
        start = 1'b1;
        op    = o;
        a     = 8'(ua);
        b     = 8'(ub);
        ci    = 1'(uci);
    endtask

    task automatic scramble();
        start = 1'b0;
        op    = alu_op_t'($urandom_range(0, 7));
        a     = 8'($urandom);
        b     = 8'($urandom);
        ci    = 1'($urandom);
    endtask

    // Issue at the current falling edge and follow the op to done.
    task automatic launch(input string tag, input alu_op_t o, input int ua, input int ub, input int uci);
        int lat;
        drive(o, ua, ub, uci);
        @(negedge clk);
        scramble();
        chk({tag, "/busy1"}, 32'(busy), 32'(exp_lat(o, ub) > 1));
        wait_done(1, lat);
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat(o, ub)));
        chk({tag, "/busy@done"}, 32'(busy), 32'(0));
        check_out(tag, o, ua, ub, uci);
    endtask

    task automatic run_op(input string tag, input alu_op_t o, input int ua, input int ub, input int uci);
        @(negedge clk);
        launch(tag, o, ua, ub, uci);
    endtask

    initial begin
        int lat;
        int nd;
        alu_op_t ro;
        int ra;
        int rb;
        int rc;

        repeat (2) @(negedge clk);
        chk("reset/busy", 32'(busy), 32'(0));
        chk("reset/done", 32'(done), 32'(0));
        chk("reset/result", 32'(result), 32'(0));
        chk("reset/result_hi", 32'(result_hi), 32'(0));
        chk("reset/nzcv", 32'({negativo, cero, acarreo, desbordamiento}), 32'(0));
        rst_n = 1'b1;

        run_op("add_7f", OP_ADD, 8'h7F, 8'h01, 0);
        run_op("add_ci", OP_ADD, 8'hFF, 8'h00, 1);
        run_op("sub_eq", OP_SUB, 8'h05, 8'h05, 0);
        run_op("sub_borrow", OP_SUB, 8'h00, 8'h01, 0);
        run_op("sub_ovf", OP_SUB, 8'h80, 8'h01, 0);
        run_op("mul_d3", OP_MUL, 8'h0D, 8'h03, 0);
        run_op("mul_ff", OP_MUL, 8'hFF, 8'hFF, 0);
        run_op("div_13_3", OP_DIV, 8'h0D, 8'h03, 0);
        run_op("mod_13_3", OP_MOD, 8'h0D, 8'h03, 0);
        run_op("div_big", OP_DIV, 8'hFF, 8'h01, 0);
        run_op("div0", OP_DIV, 8'h2A, 8'h00, 0);
        run_op("mod0", OP_MOD, 8'h11, 8'h00, 0);

        // Results hold after done.
        repeat (3) @(negedge clk);
        chk("hold/done", 32'(done), 32'(0));
        check_out("hold", OP_MOD, 8'h11, 8'h00, 0);

        // A start while busy is ignored.
        @(negedge clk);
        drive(OP_MUL, 8'h1B, 8'h05, 0);
        @(negedge clk);
        scramble();
        repeat (2) @(negedge clk);
        drive(OP_DIV, 8'h40, 8'h02, 0);
        @(negedge clk);
        scramble();
        chk("ignore/busy", 32'(busy), 32'(1));
        wait_done(4, lat);
        chk("ignore/latency", 32'(lat), 32'(W + 1));
        check_out("ignore", OP_MUL, 8'h1B, 8'h05, 0);
        @(negedge clk);
        chk("ignore/no_second_done", 32'(done), 32'(0));

        // Back-to-back issue in the DONE cycle.
        @(negedge clk);
        launch("b2b_first", OP_MUL, 8'h07, 8'h09, 0);
        launch("b2b_second", OP_SUB, 8'h03, 8'h09, 0);
        launch("b2b_third", OP_DIV, 8'hC8, 8'h07, 0);

        // Reset in the middle of an iteration.
        @(negedge clk);
        drive(OP_DIV, 8'h99, 8'h04, 0);
        @(negedge clk);
        scramble();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst/busy", 32'(busy), 32'(0));
        chk("midrst/done", 32'(done), 32'(0));
        chk("midrst/result", 32'(result), 32'(0));
        chk("midrst/result_hi", 32'(result_hi), 32'(0));
        chk("midrst/nzcv", 32'({negativo, cero, acarreo, desbordamiento}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        chk("midrst/no_done", 32'(nd), 32'(0));
        chk("midrst/idle", 32'(busy), 32'(0));
        run_op("after_rst", OP_MUL, 8'h10, 8'h10, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = alu_op_t'($urandom_range(0, 7));
            ra = int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            rc = int'($urandom_range(0, 1));
            run_op("rand", ro, ra, rb, rc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
